// File: rtl/fetch_pkg.sv
// Shared widths, constants and state encoding for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned PC_INC = 4;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_ENC = 32'h0000_0013;

  typedef enum logic [2:0] {
    REQ,
    WAIT,
    HOLD,
    DRAIN,
    FAULT
  } fetch_state_t;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational taken-branch target: br_pc + br_imm, with alignment view and misalignment flag.
module branch_target_calc
  import fetch_pkg::*;
(
  input  logic [XLEN-1:0] br_pc_i,
  input  logic [XLEN-1:0] br_imm_i,
  output logic [XLEN-1:0] target_o,
  output logic [XLEN-1:0] aligned_target_o,
  output logic            misaligned_o
);

  assign target_o         = br_pc_i + br_imm_i;
  assign aligned_target_o = {target_o[XLEN-1:2], 2'b00};
  assign misaligned_o     = |target_o[1:0];

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32 fetch stage: one-outstanding imem requests, decode handoff, branch redirects.
// Optional misaligned-target trap compiled in with FETCH_MISALIGN_CHECK_EN.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_ENC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] br_imm,
  output logic            fetch_fault
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] aligned_target;
  logic            misaligned;

  branch_target_calc u_btc (
    .br_pc_i          (br_pc),
    .br_imm_i         (br_imm),
    .target_o         (target),
    .aligned_target_o (aligned_target),
    .misaligned_o     (misaligned)
  );

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q, fault_d;
  assign fetch_fault = fault_q;
`else
  logic [XLEN:0] target_unused;
  assign target_unused = {misaligned, target};
  assign fetch_fault   = 1'b0;
`endif

  assign imem_req_valid = (state_q == REQ) && !rst;
  assign imem_req_addr  = pc_q;
  assign instr_valid    = (state_q == HOLD);
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= RESET_PC;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q    <= fault_d;
`endif
    end
  end

  // Redirect outranks every other event; otherwise the normal fetch sequence.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    fault_d    = fault_q;
`endif
    if (br_taken && (state_q != FAULT)) begin
      pc_d = aligned_target;
      case (state_q)
        REQ:     state_d = imem_req_ready ? DRAIN : REQ;
        WAIT:    state_d = imem_resp_valid ? REQ : DRAIN;
        HOLD: begin
          state_d = REQ;
          instr_d = NOP_INSTR;
        end
        default: state_d = DRAIN;
      endcase
`ifdef FETCH_MISALIGN_CHECK_EN
      if (misaligned) begin
        state_d = FAULT;
        pc_d    = target;
        fault_d = 1'b1;
        instr_d = NOP_INSTR;
      end
`endif
    end else begin
      case (state_q)
        REQ: begin
          if (imem_req_ready) state_d = WAIT;
        end
        WAIT: begin
          if (imem_resp_valid) begin
            instr_d    = imem_resp_data;
            instr_pc_d = pc_q;
            pc_d       = pc_q + XLEN'(PC_INC);
            state_d    = HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            state_d = REQ;
            instr_d = NOP_INSTR;
          end
        end
        DRAIN: begin
          if (imem_resp_valid) state_d = REQ;
        end
        FAULT:   state_d = FAULT;
        default: state_d = REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit (memory side driven by hand).
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        br_taken;
  logic [31:0] br_pc;
  logic [31:0] br_imm;
  logic        fetch_fault;

  int n_checks;
  int n_errors;

  instruction_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready),
    .br_taken        (br_taken),
    .br_pc           (br_pc),
    .br_imm          (br_imm),
    .fetch_fault     (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] pc, input logic [31:0] imm);
    br_taken = 1'b1;
    br_pc    = pc;
    br_imm   = imm;
  endtask

  // One full fetch from REQ: accept, 1-cycle response, optional stall, consume.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word, input int hold);
    check_eq("req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("req_addr", imem_req_addr, addr);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    check_eq("wait_no_req", 32'(imem_req_valid), 32'd0);
    check_eq("wait_no_valid", 32'(instr_valid), 32'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = word;
    step();
    imem_resp_valid = 1'b0;
    check_eq("hold_valid", 32'(instr_valid), 32'd1);
    check_eq("hold_instr", instr, word);
    check_eq("hold_pc", instr_pc, addr);
    for (int i = 0; i < hold; i++) begin
      step();
      check_eq("stall_valid", 32'(instr_valid), 32'd1);
      check_eq("stall_instr", instr, word);
      check_eq("stall_pc", instr_pc, addr);
      check_eq("stall_no_req", 32'(imem_req_valid), 32'd0);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check_eq("consumed_valid", 32'(instr_valid), 32'd0);
    check_eq("consumed_nop", instr, NOP);
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rst             = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    instr_ready     = 1'b0;
    br_taken        = 1'b0;
    br_pc           = 32'h0;
    br_imm          = 32'h0;

    step();
    step();
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_instr", instr, NOP);
    check_eq("rst_instr_pc", instr_pc, 32'h0);
    check_eq("rst_fault", 32'(fetch_fault), 32'd0);
    rst = 1'b0;
    #1;

    // Sequential fetches, stall on the second one
    do_fetch(32'h0000_0000, 32'hAAAA_0001, 0);
    do_fetch(32'h0000_0004, 32'hBBBB_0002, 5);
    do_fetch(32'h0000_0008, 32'hCCCC_0003, 0);

    // Redirect while waiting: response is drained, never shown to decode
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect(32'h0000_0100, 32'hFFFF_FFF0);
    step();
    br_taken = 1'b0;
    check_eq("drain_no_req", 32'(imem_req_valid), 32'd0);
    check_eq("drain_no_valid", 32'(instr_valid), 32'd0);
    step();
    check_eq("drain_still", 32'(imem_req_valid), 32'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    step();
    imem_resp_valid = 1'b0;
    check_eq("drained_no_valid", 32'(instr_valid), 32'd0);
    check_eq("drained_instr_nop", instr, NOP);
    do_fetch(32'h0000_00F0, 32'h1111_0004, 0);

    // Redirect in HOLD with instr_ready: held instruction dropped
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h2222_0005;
    step();
    imem_resp_valid = 1'b0;
    check_eq("hold2_valid", 32'(instr_valid), 32'd1);
    check_eq("hold2_pc", instr_pc, 32'h0000_00F4);
    redirect(32'h0000_0200, 32'h0000_0040);
    instr_ready = 1'b1;
    step();
    br_taken    = 1'b0;
    instr_ready = 1'b0;
    check_eq("hold_br_valid", 32'(instr_valid), 32'd0);
    check_eq("hold_br_nop", instr, NOP);

    // Redirect in REQ without ready withdraws the old request; then PC wrap
    check_eq("hold_br_addr", imem_req_addr, 32'h0000_0240);
    redirect(32'hFFFF_FF00, 32'h0000_00FC);
    step();
    br_taken = 1'b0;
    do_fetch(32'hFFFF_FFFC, 32'h3333_0006, 0);
    do_fetch(32'h0000_0000, 32'h4444_0007, 0);

    // Redirect in REQ with ready: accepted request drained
    redirect(32'h0000_0300, 32'h0000_0000);
    imem_req_ready = 1'b1;
    step();
    br_taken       = 1'b0;
    imem_req_ready = 1'b0;
    check_eq("req_br_drain", 32'(imem_req_valid), 32'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h5555_0008;
    step();
    imem_resp_valid = 1'b0;
    check_eq("req_br_valid", 32'(instr_valid), 32'd0);
    check_eq("req_br_addr", imem_req_addr, 32'h0000_0300);

    // Redirect in WAIT coinciding with response: response dropped, no pc+4
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h6666_0009;
    redirect(32'h0000_0400, 32'h0000_0010);
    step();
    imem_resp_valid = 1'b0;
    br_taken        = 1'b0;
    check_eq("wait_br_valid", 32'(instr_valid), 32'd0);
    check_eq("wait_br_req", 32'(imem_req_valid), 32'd1);
    check_eq("wait_br_addr", imem_req_addr, 32'h0000_0410);

    // Misaligned target
    redirect(32'h0000_0000, 32'h0000_0006);
    step();
    br_taken = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    check_eq("mis_fault", 32'(fetch_fault), 32'd1);
    check_eq("mis_no_req", 32'(imem_req_valid), 32'd0);
    check_eq("mis_pc_raw", imem_req_addr, 32'h0000_0006);
    imem_req_ready = 1'b1;
    redirect(32'h0000_0800, 32'h0000_0000);
    step();
    br_taken = 1'b0;
    step();
    imem_req_ready = 1'b0;
    check_eq("mis_sticky", 32'(fetch_fault), 32'd1);
    check_eq("mis_still_no_req", 32'(imem_req_valid), 32'd0);
    check_eq("mis_br_ignored", imem_req_addr, 32'h0000_0006);
    check_eq("mis_no_valid", 32'(instr_valid), 32'd0);
`else
    check_eq("mis_fault", 32'(fetch_fault), 32'd0);
    check_eq("mis_req", 32'(imem_req_valid), 32'd1);
    check_eq("mis_addr", imem_req_addr, 32'h0000_0004);
`endif

    // Reset mid-flight returns to the reset state
    rst = 1'b1;
    #1;
    check_eq("rst2_req_valid", 32'(imem_req_valid), 32'd0);
    step();
    check_eq("rst2_fault", 32'(fetch_fault), 32'd0);
    check_eq("rst2_instr_valid", 32'(instr_valid), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("rst2_req", 32'(imem_req_valid), 32'd1);
    check_eq("rst2_addr", imem_req_addr, 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage of the RV32 core; sits directly upstream of decode and the immediate generator, and supplies the 32-bit instruction word they consume.
- Holds the PC and issues one-outstanding-request fetches to instruction memory over a valid/ready request plus valid response interface.
- Presents each fetched instruction and its PC to decode with a valid/ready handshake.
- Applies taken-branch redirects: target = branch PC + sign-extended immediate.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction value driven on instr while nothing valid is held (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch byte address, word-aligned.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_resp_valid  in  1  response data valid.
- imem_resp_data  in  32  fetched instruction word.
- instr_valid  out  1  instr/instr_pc valid to decode.
- instr  out  32  instruction to decode / immediate generator.
- instr_pc  out  32  PC of instr.
- instr_ready  in  1  decode consumes instr this cycle.
- br_taken  in  1  redirect request, single-cycle pulse.
- br_pc  in  32  PC of the branch instruction.
- br_imm  in  32  sign-extended branch offset; bit 0 is always 0.
- fetch_fault  out  1  misaligned-target fault flag; see Optional Feature.

Behaviour:
- Reset (rst=1 at an edge):
  - pc=RESET_PC, state=REQ, instr_valid=0, instr=NOP_INSTR, instr_pc=RESET_PC, fetch_fault=0.
  - imem_req_valid is 0 while rst=1.
- Outputs are decoded from the state register:
  - imem_req_valid=(state==REQ).
  - imem_req_addr=pc.
  - instr_valid=(state==HOLD).
- States: REQ, WAIT, HOLD, DRAIN, FAULT.
- REQ: on req_valid & req_ready → WAIT.
- WAIT: on resp_valid:
  - instr ← resp_data, instr_pc ← pc, pc ← pc+4 (mod 2^32, wraps 0xFFFF_FFFC→0).
  - Next state HOLD.
- HOLD: instr_valid=1 and instr/instr_pc stay stable until instr_ready. On instr_ready → REQ; instr returns to NOP_INSTR.
- Latency:
  - The request is accepted at edge t and the response arrives in cycle t+k.
  - instr_valid=1 from edge t+k+1.
  - Minimum issue-to-issue period is 3 cycles.
- imem_resp_valid outside WAIT/DRAIN is ignored.
- Redirect: target = br_pc + br_imm (mod 2^32). br_taken has priority over every other event in the same cycle; pc ← target, then by state:
  - REQ without req_ready: → REQ, new address presented next cycle (unaccepted request withdrawn).
  - REQ with req_ready the same cycle: old request already accepted → DRAIN.
  - WAIT without resp_valid: → DRAIN.
  - WAIT with resp_valid: the response is discarded and pc is not incremented → REQ.
  - HOLD: the held instruction is dropped even if instr_ready=1; instr_valid=0 next cycle → REQ.
  - DRAIN: pc updated again, stays in DRAIN.
- DRAIN: waits for the one outstanding response, discards it, then → REQ.
- Alignment: target[1:0] is forced to 2'b00 when loaded into pc, unless the Optional Feature is compiled in.
- rst asserted mid-transaction: immediate return to reset state. The memory-side outstanding response is then ignored; memory guarantees no response after reset.

Optional Feature:
- Macro FETCH_MISALIGN_CHECK_EN.
- Defined:
  - A redirect with target[1:0]!=0 → FAULT (including from DRAIN).
  - fetch_fault=1 sticky until rst; no requests issued, instr_valid=0.
  - pc ← unmodified target, for trap reporting.
  - Later br_taken is ignored in FAULT.
- Undefined:
  - Bits [1:0] are cleared, no FAULT state exists, and fetch_fault is tied 0.
  - The port is present in both builds.

Decomposition:
- Package fetch_pkg:
  - XLEN=32, PC_INC=4.
  - fetch_state_t enumeration (REQ, WAIT, HOLD, DRAIN, FAULT).
  - NOP encoding constant.
- One sub-module, branch_target_calc (combinational):
  - target = br_pc + br_imm.
  - misaligned = |target[1:0].
  - Output aligned_target with [1:0] cleared.

Test Plan:
- Reset, memory ready, 1-cycle response → request addresses 0x0, 0x4, 0x8; instr_pc matches each fetch; instr equals the returned words.
- instr_ready held 0 for 5 cycles in HOLD → instr/instr_pc stable, no new imem_req_valid; release → next request 0x8.
- br_taken in WAIT with br_pc=0x100, br_imm=0xFFFF_FFF0 → DRAIN; late response discarded, never valid to decode; next request 0xF0.
- br_taken in HOLD with instr_ready=1 → held instruction not consumed; next request = target.
- pc=0xFFFF_FFFC fetch → next request address 0x0000_0000.
- br_imm=0x6 from br_pc=0x0:
  - FETCH_MISALIGN_CHECK_EN defined: fetch_fault=1, no further requests.
  - Undefined: next request 0x4, fetch_fault=0.
